// File: rtl/usb_pkg.sv
// Shared token field layout, PID codes and arbiter state encoding for usb_ep_arbiter.
package usb_pkg;

  localparam int TOK_W    = 24;
  localparam int PID_LSB  = 0;
  localparam int PID_W    = 8;
  localparam int ADDR_LSB = 8;
  localparam int ADDR_W   = 7;
  localparam int ENDP_LSB = 15;
  localparam int ENDP_W   = 4;
  localparam int CRC5_LSB = 19;
  localparam int CRC5_W   = 5;
  // The decoder never looks at CRC5, so it only receives the bits below it.
  localparam int DEC_W    = ENDP_LSB + ENDP_W;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_SOF   = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RX      = 2'd1,
    ST_WAIT_EP = 2'd2,
    ST_TX      = 2'd3
  } arb_state_t;

endpackage

// File: rtl/usb_token_decode.sv
// Combinational token split: address match, endpoint range check, PID class.
module usb_token_decode
  import usb_pkg::*;
#(
  parameter int N_EP = 4
) (
  input  logic [DEC_W-1:0]  tok_i,
  input  logic [ADDR_W-1:0] dev_addr_i,
  output logic              accept_o,
  output logic              is_in_o,
  output logic [ENDP_W-1:0] endp_o
);

  logic [PID_W-1:0]  w_pid;
  logic [ADDR_W-1:0] w_addr;
  logic              w_pid_ok;
  logic              w_ep_ok;

  assign w_pid    = tok_i[PID_LSB  +: PID_W];
  assign w_addr   = tok_i[ADDR_LSB +: ADDR_W];
  assign endp_o   = tok_i[ENDP_LSB +: ENDP_W];

  assign is_in_o  = (w_pid == PID_IN);
  assign w_pid_ok = (w_pid == PID_OUT) || (w_pid == PID_IN) || (w_pid == PID_SETUP);
  assign w_ep_ok  = ({1'b0, endp_o} < (ENDP_W + 1)'(N_EP));
  assign accept_o = w_pid_ok && w_ep_ok && (w_addr == dev_addr_i);

endmodule

// File: rtl/usb_ep_arbiter.sv
// Steers the shared USB token/data channel to one of N_EP endpoint controllers.
// Optional drop/timeout counter on drop_cnt_o when USB_EP_ARB_STATS_EN is defined.
//
// state      | meaning
// ST_IDLE    | no transaction, waiting for an accepted token
// ST_RX      | host data routed to ep[sel] until rx end/fail
// ST_WAIT_EP | IN token issued, waiting for ep[sel] start pulse (timeout counter runs)
// ST_TX      | ep[sel] reply muxed upstream until stop pulse or tx fail
module usb_ep_arbiter
  import usb_pkg::*;
#(
  parameter int N_EP        = 4,
  parameter int TIMEOUT_CYC = 96,
  parameter int TO_W        = 7
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [6:0]        dev_addr_i,
  input  logic [TOK_W-1:0]  tok_i,
  input  logic              tok_strb_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_strb_i,
  input  logic              rx_end_i,
  input  logic              rx_fail_i,
  input  logic [7:0]        pid_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_start_stop_o,
  input  logic              tx_strb_i,
  input  logic              tx_fail_i,
  output logic [TOK_W-1:0]  ep_tok_o,
  output logic [N_EP-1:0]   ep_tok_strb_o,
  output logic [7:0]        ep_rx_data_o,
  output logic [7:0]        ep_pid_o,
  output logic [N_EP-1:0]   ep_rx_strb_o,
  output logic [N_EP-1:0]   ep_rx_end_o,
  output logic [N_EP-1:0]   ep_rx_fail_o,
  input  logic [8*N_EP-1:0] ep_tx_data_i,
  input  logic [N_EP-1:0]   ep_tx_start_stop_i,
  output logic [N_EP-1:0]   ep_tx_strb_o,
  output logic [N_EP-1:0]   ep_tx_fail_o,
  output logic              busy_o
`ifdef USB_EP_ARB_STATS_EN
  ,
  output logic [15:0]       drop_cnt_o
`endif
);

  arb_state_t        r_state, w_state_nxt;
  logic [ENDP_W-1:0] r_sel, w_sel_nxt, w_endp;
  logic [TO_W-1:0]   r_cnt, w_cnt_nxt;
  logic              w_accept, w_is_in, w_tok_acc, w_start, w_timeout;
  logic [N_EP-1:0]   w_sel_oh, w_endp_oh;
  logic [7:0]        w_tx_mux;
  logic [N_EP-1:0]   w_rx_strb_nxt, w_rx_end_nxt, w_rx_fail_nxt, w_tx_fail_nxt;
  logic [TOK_W-1:0]  r_tok;
  logic [N_EP-1:0]   r_tok_strb, r_rx_strb, r_rx_end, r_rx_fail, r_tx_fail;
  logic [7:0]        r_rx_data, r_pid;

  usb_token_decode #(.N_EP(N_EP)) u_dec (
    .tok_i      (tok_i[DEC_W-1:0]),
    .dev_addr_i (dev_addr_i),
    .accept_o   (w_accept),
    .is_in_o    (w_is_in),
    .endp_o     (w_endp)
  );

  always_comb begin
    w_sel_oh  = '0;
    w_endp_oh = '0;
    w_tx_mux  = '0;
    for (int k = 0; k < N_EP; k++) begin
      w_sel_oh[k]  = (r_sel == ENDP_W'(k));
      w_endp_oh[k] = (w_endp == ENDP_W'(k));
      if (r_sel == ENDP_W'(k)) w_tx_mux = ep_tx_data_i[8*k +: 8];
    end
  end

  assign w_tok_acc = tok_strb_i && w_accept;
  assign w_start   = |(ep_tx_start_stop_i & w_sel_oh);
  assign w_timeout = (r_state == ST_WAIT_EP) && !w_start && (r_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RX:      if (rx_end_i || rx_fail_i) w_state_nxt = ST_IDLE;
      ST_WAIT_EP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_start)        w_state_nxt = ST_TX;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      ST_TX:      if (w_start || tx_fail_i) w_state_nxt = ST_IDLE;
      default:    ;
    endcase
    // An accepted token always wins: it aborts whatever was running and starts afresh.
    if (w_tok_acc) begin
      w_sel_nxt   = w_endp;
      w_cnt_nxt   = '0;
      w_state_nxt = w_is_in ? ST_WAIT_EP : ST_RX;
    end
  end

  always_comb begin
    tx_data_o       = '0;
    tx_start_stop_o = 1'b0;
    ep_tx_strb_o    = '0;
    ep_tx_fail_o    = r_tx_fail;
    w_rx_strb_nxt   = '0;
    w_rx_end_nxt    = '0;
    w_rx_fail_nxt   = '0;
    w_tx_fail_nxt   = '0;
    case (r_state)
      ST_RX: begin
        if (rx_strb_i) w_rx_strb_nxt = w_sel_oh;
        if (rx_end_i)  w_rx_end_nxt  = w_sel_oh;
        if (rx_fail_i || (w_tok_acc && !rx_end_i)) w_rx_fail_nxt = w_sel_oh;
      end
      ST_WAIT_EP: begin
        tx_start_stop_o = w_start;
        if (w_timeout || w_tok_acc) w_tx_fail_nxt = w_sel_oh;
      end
      ST_TX: begin
        tx_data_o       = w_tx_mux;
        tx_start_stop_o = w_start;
        if (tx_strb_i) ep_tx_strb_o = w_sel_oh;
        if (tx_fail_i) ep_tx_fail_o = r_tx_fail | w_sel_oh;
        if (w_tok_acc) w_tx_fail_nxt = w_sel_oh;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tok      <= '0;
      r_tok_strb <= '0;
      r_rx_data  <= '0;
      r_pid      <= '0;
      r_rx_strb  <= '0;
      r_rx_end   <= '0;
      r_rx_fail  <= '0;
      r_tx_fail  <= '0;
    end else begin
      r_tok_strb <= w_tok_acc ? w_endp_oh : '0;
      if (w_tok_acc) r_tok <= tok_i;
      if (r_state == ST_RX) begin
        r_pid <= pid_i;
        if (rx_strb_i) r_rx_data <= rx_data_i;
      end
      r_rx_strb <= w_rx_strb_nxt;
      r_rx_end  <= w_rx_end_nxt;
      r_rx_fail <= w_rx_fail_nxt;
      r_tx_fail <= w_tx_fail_nxt;
    end
  end

  assign ep_tok_o      = r_tok;
  assign ep_tok_strb_o = r_tok_strb;
  assign ep_rx_data_o  = r_rx_data;
  assign ep_pid_o      = r_pid;
  assign ep_rx_strb_o  = r_rx_strb;
  assign ep_rx_end_o   = r_rx_end;
  assign ep_rx_fail_o  = r_rx_fail;
  assign busy_o        = (r_state != ST_IDLE);

`ifdef USB_EP_ARB_STATS_EN
  logic        w_is_sof;
  logic [1:0]  w_drop_inc;
  logic [16:0] w_drop_sum;
  logic [15:0] r_drop_cnt;

  assign w_is_sof   = (tok_i[PID_LSB +: PID_W] == PID_SOF);
  assign w_drop_inc = {1'b0, tok_strb_i && !w_accept && !w_is_sof} + {1'b0, w_timeout};
  assign w_drop_sum = {1'b0, r_drop_cnt} + {15'd0, w_drop_inc};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_drop_cnt <= '0;
    else       r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  assign drop_cnt_o = r_drop_cnt;
`endif

endmodule

// File: tb/tb_usb_ep_arbiter.sv
// Randomized self-checking bench for usb_ep_arbiter; checks drop_cnt_o when USB_EP_ARB_STATS_EN is defined.
module tb_usb_ep_arbiter;

  localparam int         N_EP        = 4;
  localparam int         TIMEOUT_CYC = 96;
  localparam logic [6:0] DEV         = 7'h05;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic [6:0]        dev_addr_i = DEV;
  logic [23:0]       tok_i = '0;
  logic              tok_strb_i = 1'b0;
  logic [7:0]        rx_data_i = '0;
  logic              rx_strb_i = 1'b0, rx_end_i = 1'b0, rx_fail_i = 1'b0;
  logic [7:0]        pid_i = '0;
  logic [7:0]        tx_data_o;
  logic              tx_start_stop_o;
  logic              tx_strb_i = 1'b0, tx_fail_i = 1'b0;
  logic [23:0]       ep_tok_o;
  logic [N_EP-1:0]   ep_tok_strb_o;
  logic [7:0]        ep_rx_data_o, ep_pid_o;
  logic [N_EP-1:0]   ep_rx_strb_o, ep_rx_end_o, ep_rx_fail_o;
  logic [8*N_EP-1:0] ep_tx_data_i = '0;
  logic [N_EP-1:0]   ep_tx_start_stop_i = '0;
  logic [N_EP-1:0]   ep_tx_strb_o, ep_tx_fail_o;
  logic              busy_o;
`ifdef USB_EP_ARB_STATS_EN
  logic [15:0]       drop_cnt_o;
`endif

  usb_ep_arbiter #(.N_EP(N_EP), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(7)) dut (
    .clk(clk), .nrst(nrst), .dev_addr_i(dev_addr_i), .tok_i(tok_i), .tok_strb_i(tok_strb_i),
    .rx_data_i(rx_data_i), .rx_strb_i(rx_strb_i), .rx_end_i(rx_end_i), .rx_fail_i(rx_fail_i),
    .pid_i(pid_i), .tx_data_o(tx_data_o), .tx_start_stop_o(tx_start_stop_o),
    .tx_strb_i(tx_strb_i), .tx_fail_i(tx_fail_i), .ep_tok_o(ep_tok_o),
    .ep_tok_strb_o(ep_tok_strb_o), .ep_rx_data_o(ep_rx_data_o), .ep_pid_o(ep_pid_o),
    .ep_rx_strb_o(ep_rx_strb_o), .ep_rx_end_o(ep_rx_end_o), .ep_rx_fail_o(ep_rx_fail_o),
    .ep_tx_data_i(ep_tx_data_i), .ep_tx_start_stop_i(ep_tx_start_stop_i),
    .ep_tx_strb_o(ep_tx_strb_o), .ep_tx_fail_o(ep_tx_fail_o), .busy_o(busy_o)
`ifdef USB_EP_ARB_STATS_EN
    , .drop_cnt_o(drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int model_drops = 0;
  logic [7:0] pids [6] = '{8'hE1, 8'h69, 8'h2D, 8'hA5, 8'hC3, 8'h4B};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit tok_ok(logic [7:0] pid, logic [6:0] addr, logic [3:0] endp);
    return (addr == DEV) && (int'(endp) < N_EP) && (pid == 8'hE1 || pid == 8'h69 || pid == 8'h2D);
  endfunction

  function automatic logic [N_EP-1:0] oh(int k);
    return N_EP'(1) << k;
  endfunction

  task automatic clr_in();
    tok_strb_i = 0; rx_strb_i = 0; rx_end_i = 0; rx_fail_i = 0;
    tx_strb_i = 0; tx_fail_i = 0; ep_tx_start_stop_i = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
    clr_in();
  endtask

  task automatic do_reset();
    nrst = 0;
    clr_in();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_tokstrb", ep_tok_strb_o, 0);
    chk("rst_txfail", ep_tx_fail_o, 0);
    model_drops = 0;
`ifdef USB_EP_ARB_STATS_EN
    chk("rst_drop", drop_cnt_o, 0);
`endif
    nrst = 1;
    cyc();
  endtask

  // Drives one token for one cycle; returns at the following falling edge.
  task automatic send_tok(input logic [7:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                          output bit acc);
    logic [23:0] t;
    t = {5'($urandom), endp, addr, pid};
    tok_i = t;
    tok_strb_i = 1;
    cyc();
    acc = tok_ok(pid, addr, endp);
    if (!acc && pid != 8'hA5) model_drops++;
    chk("tok_strb", ep_tok_strb_o, acc ? oh(int'(endp)) : 0);
    if (acc) chk("tok_val", ep_tok_o, t);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int ep, nb, dly, n, cur;
    bit acc, use_fail, sb, cur_tx;
    logic [7:0] pid, dpid, d;
    logic [7:0] lane [N_EP];
    logic [6:0] addr;
    logic [3:0] endp;

    do_reset();

    // OUT/SETUP transactions
    for (int t = 0; t < 6; t++) begin
      ep = (t == 0) ? 2 : $urandom_range(N_EP - 1);
      nb = (t == 0) ? 2 : $urandom_range(1, 4);
      pid = (t == 0 || $urandom_range(1) == 0) ? 8'hE1 : 8'h2D;
      dpid = ($urandom_range(1) == 0) ? 8'hC3 : 8'h4B;
      use_fail = (t != 0) && ($urandom_range(3) == 0);
      send_tok(pid, DEV, 4'(ep), acc);
      chk("rx_busy", busy_o, 1);
      pid_i = dpid;
      for (int b = 0; b < nb; b++) begin
        d = (t == 0) ? ((b == 0) ? 8'h11 : 8'h22) : 8'($urandom);
        rx_data_i = d;
        rx_strb_i = 1;
        cyc();
        chk("rx_strb", ep_rx_strb_o, oh(ep));
        chk("rx_data", ep_rx_data_o, d);
        chk("rx_pid", ep_pid_o, dpid);
        repeat ($urandom_range(0, 2)) begin
          cyc();
          chk("rx_gap", ep_rx_strb_o, 0);
        end
      end
      if (use_fail) rx_fail_i = 1;
      else          rx_end_i = 1;
      cyc();
      chk("rx_end", ep_rx_end_o, use_fail ? 0 : oh(ep));
      chk("rx_fail", ep_rx_fail_o, use_fail ? oh(ep) : 0);
      chk("rx_idle", busy_o, 0);
      cyc();
      chk("rx_clr", ep_rx_end_o | ep_rx_fail_o | ep_rx_strb_o, 0);
    end

    // IN transactions with endpoint reply
    for (int t = 0; t < 5; t++) begin
      ep = (t == 0) ? 1 : $urandom_range(N_EP - 1);
      nb = (t == 0) ? 3 : $urandom_range(1, 4);
      dly = (t == 0) ? 10 : $urandom_range(1, 20);
      use_fail = (t != 0) && ($urandom_range(2) == 0);
      send_tok(8'h69, DEV, 4'(ep), acc);
      chk("in_busy", busy_o, 1);
      repeat (dly) begin
        ep_tx_start_stop_i = oh((ep + 1) % N_EP);
        #1;
        chk("wait_ign", tx_start_stop_o, 0);
        chk("wait_data", tx_data_o, 0);
        cyc();
      end
      ep_tx_start_stop_i = oh(ep);
      #1;
      chk("tx_start", tx_start_stop_o, 1);
      cyc();
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < N_EP; k++) begin
          lane[k] = 8'($urandom);
          ep_tx_data_i[8*k +: 8] = lane[k];
        end
        sb = 1'($urandom_range(1));
        tx_strb_i = sb;
        #1;
        chk("tx_data", tx_data_o, lane[ep]);
        chk("tx_strb", ep_tx_strb_o, sb ? oh(ep) : 0);
        chk("tx_ss", tx_start_stop_o, 0);
        chk("tx_busy", busy_o, 1);
        cyc();
      end
      if (use_fail) begin
        tx_fail_i = 1;
        #1;
        chk("tx_fail", ep_tx_fail_o, oh(ep));
      end else begin
        ep_tx_start_stop_i = oh(ep);
        #1;
        chk("tx_stop", tx_start_stop_o, 1);
      end
      cyc();
      chk("tx_idle", busy_o, 0);
      ep_tx_data_i = {N_EP{8'hFF}};
      tx_strb_i = 1;
      #1;
      chk("tx_data_idle", tx_data_o, 0);
      chk("tx_strb_idle", ep_tx_strb_o, 0);
      chk("tx_fail_idle", ep_tx_fail_o, 0);
      cyc();
    end

    // IN token with no reply: timeout
    for (int t = 0; t < 2; t++) begin
      ep = (t == 0) ? 3 : $urandom_range(N_EP - 1);
      send_tok(8'h69, DEV, 4'(ep), acc);
      n = 0;
      while (ep_tx_fail_o == '0 && n < 200) begin
        cyc();
        n++;
      end
      model_drops++;
      chk("to_lat", n, TIMEOUT_CYC);
      chk("to_oh", ep_tx_fail_o, oh(ep));
      chk("to_idle", busy_o, 0);
      cyc();
      chk("to_clr", ep_tx_fail_o, 0);
    end
`ifdef USB_EP_ARB_STATS_EN
    chk("drop_to", drop_cnt_o, model_drops);
`endif

    // Directed dropped tokens
    do_reset();
    send_tok(8'hE1, 7'd6, 4'd2, acc);
    chk("drop_addr_busy", busy_o, 0);
    send_tok(8'h69, DEV, 4'd7, acc);
    chk("drop_endp_busy", busy_o, 0);
    send_tok(8'hA5, DEV, 4'd0, acc);
    chk("drop_sof_busy", busy_o, 0);
`ifdef USB_EP_ARB_STATS_EN
    chk("drop_cnt", drop_cnt_o, model_drops);
`endif

    // Random token storm: acceptance, drops and preemption against the model
    cur = -1;
    cur_tx = 0;
    for (int i = 0; i < 16; i++) begin
      pid = pids[$urandom_range(5)];
      addr = ($urandom_range(3) == 0) ? 7'($urandom) : DEV;
      endp = 4'($urandom_range(7));
      send_tok(pid, addr, endp, acc);
      chk("st_rxfail", ep_rx_fail_o, (acc && cur >= 0 && !cur_tx) ? oh(cur) : 0);
      chk("st_txfail", ep_tx_fail_o, (acc && cur >= 0 && cur_tx) ? oh(cur) : 0);
      if (acc) begin
        cur = int'(endp);
        cur_tx = (pid == 8'h69);
      end
      chk("st_busy", busy_o, (cur >= 0) ? 1 : 0);
      repeat ($urandom_range(0, 2)) cyc();
    end
`ifdef USB_EP_ARB_STATS_EN
    chk("st_drop", drop_cnt_o, model_drops);
`endif

    // rx_end coinciding with a new token
    do_reset();
    send_tok(8'h2D, DEV, 4'd2, acc);
    rx_end_i = 1;
    send_tok(8'h69, DEV, 4'd3, acc);
    chk("co_end", ep_rx_end_o, oh(2));
    chk("co_fail", ep_rx_fail_o, 0);
    chk("co_busy", busy_o, 1);

    // OUT preempted by IN, then reset during the reply
    do_reset();
    send_tok(8'hE1, DEV, 4'd0, acc);
    rx_data_i = 8'hAB;
    rx_strb_i = 1;
    cyc();
    chk("pre_rx", ep_rx_strb_o, oh(0));
    send_tok(8'h69, DEV, 4'd1, acc);
    chk("pre_fail", ep_rx_fail_o, oh(0));
    chk("pre_busy", busy_o, 1);
    ep_tx_start_stop_i = oh(1);
    #1;
    chk("pre_start", tx_start_stop_o, 1);
    cyc();
    ep_tx_data_i = 32'hA1B2C3D4;
    tx_strb_i = 1;
    #1;
    chk("mid_data", tx_data_o, 8'hC3);
    #1;
    nrst = 0;
    #1;
    chk("arst_data", tx_data_o, 0);
    chk("arst_strb", ep_tx_strb_o, 0);
    chk("arst_busy", busy_o, 0);
    cyc();
    nrst = 1;
    model_drops = 0;
    ep_tx_start_stop_i = oh(1);
    #1;
    chk("post_ign", tx_start_stop_o, 0);
    cyc();
    chk("post_busy", busy_o, 0);
    send_tok(8'h69, DEV, 4'd1, acc);
    ep_tx_start_stop_i = oh(1);
    #1;
    chk("post_start", tx_start_stop_o, 1);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/usb_ep_arbiter.md
Name: usb_ep_arbiter

Overview:
Sits between usb_handshake_multiplexer and N endpoint controllers. It shares that block's single token/data channel among N_EP endpoints. Each token is decoded, filtered by device address, and steered to the endpoint selected by its ENDP field. The block holds that selection for the transaction: host data goes to the selected endpoint, and that endpoint's reply data returns upstream. An endpoint that fails to answer an IN token within TIMEOUT_CYC cycles is timed out.

Parameters:
N_EP, 4, number of endpoint controllers (1..16)
TIMEOUT_CYC, 96, clk cycles allowed between IN token and endpoint start pulse
TO_W, 7, timeout counter width (must satisfy 2^TO_W > TIMEOUT_CYC)

Ports:
clk  in  1  60 MHz USB PHY clock
nrst  in  1  asynchronous active-low reset
dev_addr_i  in  7  assigned device address
tok_i  in  24  token from multiplexer
tok_strb_i  in  1  token valid pulse
rx_data_i  in  8  host data byte
rx_strb_i  in  1  rx byte valid
rx_end_i  in  1  rx packet end pulse
rx_fail_i  in  1  rx packet CRC/PID failure pulse
pid_i  in  8  PID of current data packet
tx_data_o  out  8  reply byte to multiplexer
tx_start_stop_o  out  1  reply start/stop pulse
tx_strb_i  in  1  multiplexer consumed tx byte
tx_fail_i  in  1  reply transmission failed
ep_tok_o  out  24  token broadcast to endpoints
ep_tok_strb_o  out  N_EP  one-hot token pulse
ep_rx_data_o  out  8  broadcast rx byte
ep_pid_o  out  8  broadcast PID
ep_rx_strb_o / ep_rx_end_o / ep_rx_fail_o  out  N_EP each  one-hot rx qualifiers
ep_tx_data_i  in  8*N_EP  endpoint reply bytes; ep k occupies bits [8k+7:8k]
ep_tx_start_stop_i  in  N_EP  endpoint start/stop pulses
ep_tx_strb_o  out  N_EP  one-hot consume strobe
ep_tx_fail_o  out  N_EP  one-hot fail
busy_o  out  1  transaction in progress

Behaviour:
- One clock domain (clk); reset asynchronous, active-low (nrst).
- Reset: all outputs 0, state IDLE, sel=0, timeout counter=0.
- Token fields: PID=tok[7:0], ADDR=tok[14:8], ENDP=tok[18:15], CRC5=tok[23:19].
- Token acceptance: ADDR==dev_addr_i, ENDP<N_EP, and PID is one of OUT 0xE1, IN 0x69, SETUP 0x2D. Any other token, including SOF 0xA5, is dropped: no endpoint strobe, state unchanged unless the preemption rule applies.
- Accepted token:
  - sel<=ENDP.
  - ep_tok_o and ep_tok_strb_o[ENDP] registered; 1-cycle latency after tok_strb_i.
- States:
  - IDLE: on accepted OUT/SETUP go to RX; on accepted IN go to WAIT_EP and clear the counter.
  - RX: rx_* routed to ep[sel] with 1-cycle registered latency. rx_end_i or rx_fail_i is forwarded, then go to IDLE.
  - WAIT_EP: counter increments each cycle.
    - ep_tx_start_stop_i[sel] pulse: forward to tx_start_stop_o, go to TX.
    - Counter reaches TIMEOUT_CYC-1: go to IDLE, pulse ep_tx_fail_o[sel] for 1 cycle.
  - TX: tx_data_o=ep_tx_data_i[sel] and tx_start_stop_o=ep_tx_start_stop_i[sel] (combinational mux, 0 latency). ep_tx_strb_o[sel]=tx_strb_i. Second start_stop pulse or tx_fail_i (forwarded to ep_tx_fail_o[sel]) returns to IDLE.
- Outside TX: tx_data_o=0, tx_start_stop_o=0, and ep_tx_strb_o/ep_tx_fail_o are 0 except the timeout pulse.
- Start/stop pulses from non-selected endpoints are ignored in every state.
- Preemption: an accepted token in any non-IDLE state aborts the current transaction. It pulses ep_rx_fail_o[old sel] if in RX, or ep_tx_fail_o[old sel] if in WAIT_EP/TX, then applies the new token in the same cycle. Dropped tokens never preempt.
- Simultaneous token accept and rx_end_i in RX: end is forwarded to the old sel, and the token is then processed as from IDLE.
- busy_o=1 in RX, WAIT_EP, TX.
- Reset mid-transaction: immediate return to IDLE; outputs forced 0 asynchronously.

Optional Feature:
USB_EP_ARB_STATS_EN
- Defined: adds output drop_cnt_o[15:0], a saturating count of dropped tokens (SOF excluded) plus timeouts. Cleared by reset; holds at 0xFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package usb_pkg: token field bit positions/widths, PID constants (OUT, IN, SETUP, SOF), state enum typedef.
- Sub-module usb_token_decode: combinational field split, address match, and accept flag/ENDP index.

Test Plan:
- dev_addr=0x05, token PID 0xE1 ADDR 5 ENDP 2; rx bytes 0x11,0x22 then rx_end -> ep_tok_strb_o=4'b0100 one cycle later; ep_rx_strb_o[2] pulses twice with data 0x11,0x22; ep_rx_end_o[2] pulses; state returns to IDLE.
- IN token to ENDP 1; ep1 start after 10 cycles, 3 bytes, stop -> tx_data_o tracks ep_tx_data_i[15:8] with 0 latency; ep_tx_strb_o[1] mirrors tx_strb_i; busy_o falls after stop.
- IN token to ENDP 3; no response -> ep_tx_fail_o[3] pulses exactly 96 cycles after WAIT_EP entry; state returns to IDLE.
- Tokens with ADDR 6, with ENDP 7 (N_EP=4), and SOF 0xA5 -> no ep_tok_strb_o pulse; with USB_EP_ARB_STATS_EN, drop_cnt_o=2.
- OUT token to ep0, mid-packet IN token to ep1 -> ep_rx_fail_o[0] pulses; ep_tok_strb_o[1] pulses; state WAIT_EP.
- nrst asserted during TX -> all outputs 0 immediately; after release, ep_tx_start_stop_i pulses ignored until a new IN token.
